regfile_wb_scheduler: RTL
=========================

// Module: regfile_wb_scheduler
// PURPOSE
//  Shares the single register-file write port between NUM_REQ writeback sources (ALU, LSU, MULDIV) using round-robin.
//  Tracks in-flight destination registers in a 32-entry scoreboard.
//  Raises a stall to the issue stage on RAW/WAW hazards.
//  Sits between the execute units and the register file; drives rd / regWriteData / reg_WE_L.
// PARAMETERS
//  NUM_REQ  3   number of writeback requesters (2..8)
//  XLEN     32  data width
//  AW       5   register address width
// PORTS
//  clock         in   1            single clock, rising edge
//  reset         in   1            synchronous, active-high
//  wb_valid      in   NUM_REQ      requester i has a result
//  wb_rd         in   NUM_REQ*AW   dest reg, slice i
//  wb_data       in   NUM_REQ*XLEN result, slice i
//  wb_ready      out  NUM_REQ      one-hot grant; transfer when valid&ready
//  issue_valid   in   1            decode wants to issue an instr
//  issue_rs1     in   AW           source 1
//  issue_rs2     in   AW           source 2
//  issue_rd      in   AW           destination (0 = no write)
//  issue_stall   out  1            hazard; instr must not issue
//  rd            out  AW           regfile write address (registered)
//  regWriteData  out  XLEN         regfile write data (registered)
//  reg_WE_L      out  1            regfile write enable, active-low (registered)
//  byp1_valid    out  1            forward regWriteData for rs1
//  byp2_valid    out  1            forward regWriteData for rs2
// BEHAVIOUR
//  Reset (synchronous): pending=0, rr_ptr=0, reg_WE_L=1, rd=0, regWriteData=0, wb_ready=0.
//  Arbitration:
//   - Combinational round-robin over wb_valid, starting at rr_ptr.
//   - At most one wb_ready high; wb_ready=0 while reset is high.
//   - On transfer of grant g: rr_ptr<=g+1, mod NUM_REQ.
//  Requester rule: valid/rd/data held stable until ready; no retraction.
//  Write stage:
//   - On transfer: rd<=wb_rd[g], regWriteData<=wb_data[g], reg_WE_L<=0.
//   - With no transfer: reg_WE_L<=1.
//   - Latency: 1 cycle from handshake to reg_WE_L low; throughput 1 write/cycle.
//   - A transfer with wb_rd=0 still occupies the slot and drives reg_WE_L low.
//  Scoreboard pending[31:0]:
//   - pending[0] is always 0.
//   - Set pending[issue_rd] when issue_valid & !issue_stall & issue_rd!=0.
//   - Clear pending[rd] on the edge where reg_WE_L==0, i.e. the same edge the regfile captures.
//   - Set and clear of the same reg in one cycle: set wins.
//  issue_stall = issue_valid & (pending[rs1] | pending[rs2] | pending[issue_rd]); the last term is a WAW stall.
//  Reset mid-operation discards a queued write (reg_WE_L forced 1) and clears all pending bits.
//  Requester result for a non-pending rd: accepted and written, with no scoreboard change.
// CONFIGURATION
//  Macro: REGFILE_BYPASS_EN
//  Defined:
//   - byp1_valid = !reg_WE_L & rd!=0 & rd==issue_rs1; byp2_valid likewise for rs2.
//   - A bypassed operand does not contribute to issue_stall, even if its pending bit is set.
//  Undefined:
//   - byp1_valid=byp2_valid=0.
//   - Stall holds until pending clears, i.e. the cycle after the write.
// STRUCTURE
//  Shared package regfile_pkg:
//   - XLEN, AW, NUM_REGS=32.
//   - typedef reg_addr_t (logic [AW-1:0]) and xdata_t (logic [XLEN-1:0]).
//   - enum wb_src_e {WB_ALU=0, WB_LSU=1, WB_MULDIV=2}.
//  Sub-module rr_arbiter #(N):
//   - inputs req, ptr; output one-hot gnt.
//   - combinational; rr_ptr is owned here in the parent.
//  Target size: roughly 200 lines.
// TESTING
//  1 Reset: hold reset 2 cycles with wb_valid=3'b111 -> wb_ready=0, reg_WE_L=1, issue_stall=0.
//  2 Round-robin: wb_valid=3'b111 held 6 cycles -> grants 0,1,2,0,1,2; each write appears 1 cycle later.
//  3 RAW: issue rd=5, then issue rs1=5 -> stall.
//     - ALU writes x5=0xDEADBEEF; stall drops the cycle after reg_WE_L low.
//     - With REGFILE_BYPASS_EN: stall drops in the reg_WE_L-low cycle with byp1_valid=1.
//  4 Set/clear collision: x7 write commits in the same cycle a new issue of rd=7 is accepted -> pending[7]=1 afterwards.
//  5 x0: issue rd=0 -> no pending bit. wb_rd=0 write -> reg_WE_L low, no scoreboard effect, rs1=0 never stalls.
//  6 Reset mid-op: LSU handshake, then reset asserted next cycle -> reg_WE_L=1 and pending=0 one edge later.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback scheduler.
// Default widths, register count and writeback source encodings.
package regfile_pkg;

    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int NUM_REGS = 32;

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xdata_t;

    typedef enum logic [1:0] {
        WB_ALU    = 2'd0,
        WB_LSU    = 2'd1,
        WB_MULDIV = 2'd2
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts at ptr and wraps. The pointer register itself is owned by the parent.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    localparam logic [N-1:0] ONE_C  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] ZERO_C = {N{1'b0}};

    logic [N-1:0] mask_s;
    logic [N-1:0] masked_s;

    // Prefer the lowest request at or above ptr; otherwise wrap to the lowest request overall.
    always_comb begin
        mask_s   = ~((ONE_C << ptr) - ONE_C);
        masked_s = req & mask_s;
        if (masked_s != ZERO_C) begin
            gnt = masked_s & (~masked_s + ONE_C);
        end else begin
            gnt = req & (~req + ONE_C);
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler.
// Shares the single regfile write port between NUM_REQ writeback sources with round-robin.
// Tracks in-flight destinations in a 32-entry scoreboard and stalls issue on RAW/WAW hazards.
// Optional feature macro: REGFILE_BYPASS_EN (forward the write being committed to the issue
// stage, so that a bypassed source operand does not stall).
module regfile_wb_scheduler #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32,
    parameter int AW      = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      wb_valid,
    input  logic [NUM_REQ*AW-1:0]   wb_rd,
    input  logic [NUM_REQ*XLEN-1:0] wb_data,
    output logic [NUM_REQ-1:0]      wb_ready,
    input  logic                    issue_valid,
    input  logic [AW-1:0]           issue_rs1,
    input  logic [AW-1:0]           issue_rs2,
    input  logic [AW-1:0]           issue_rd,
    output logic                    issue_stall,
    output logic [AW-1:0]           rd,
    output logic [XLEN-1:0]         regWriteData,
    output logic                    reg_WE_L,
    output logic                    byp1_valid,
    output logic                    byp2_valid
);

    import regfile_pkg::*;

    localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NREG = NUM_REGS;

    localparam logic [NREG-1:0] REG_ONE_C  = {{(NREG-1){1'b0}}, 1'b1};
    localparam logic [NREG-1:0] REG_ZERO_C = {NREG{1'b0}};
    localparam logic [AW-1:0]   AW_ZERO_C  = {AW{1'b0}};

    logic [PW-1:0]      rr_ptr_r;
    logic [NREG-1:0]    pending_r;
    logic [AW-1:0]      rd_r;
    logic [XLEN-1:0]    data_r;
    logic               we_l_r;

    logic [NUM_REQ-1:0] gnt_s;
    logic [NUM_REQ-1:0] ready_s;
    logic               xfer_s;
    logic [PW-1:0]      gidx_s;
    logic [PW-1:0]      ptr_next_s;
    logic [AW-1:0]      sel_rd_s;
    logic [XLEN-1:0]    sel_data_s;
    logic               byp1_s;
    logic               byp2_s;
    logic               haz1_s;
    logic               haz2_s;
    logic               stall_s;
    logic               issue_fire_s;
    logic [NREG-1:0]    set_vec_s;
    logic [NREG-1:0]    clr_vec_s;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_arb (
        .req (wb_valid),
        .ptr (rr_ptr_r),
        .gnt (gnt_s)
    );

    // No grant is offered while the block is held in reset.
    always_comb begin
        if (reset) begin
            ready_s = {NUM_REQ{1'b0}};
        end else begin
            ready_s = gnt_s;
        end
        xfer_s = |ready_s;
    end

    // Encode the one-hot grant and mux out the winning requester's rd/data.
    always_comb begin
        gidx_s     = {PW{1'b0}};
        sel_rd_s   = {AW{1'b0}};
        sel_data_s = {XLEN{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            gidx_s     = gidx_s | (gnt_s[i] ? PW'(i) : {PW{1'b0}});
            sel_rd_s   = sel_rd_s | (wb_rd[i*AW +: AW] & {AW{gnt_s[i]}});
            sel_data_s = sel_data_s | (wb_data[i*XLEN +: XLEN] & {XLEN{gnt_s[i]}});
        end
        if (gidx_s == PW'(NUM_REQ - 1)) begin
            ptr_next_s = {PW{1'b0}};
        end else begin
            ptr_next_s = gidx_s + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // Round-robin pointer moves past the requester that just transferred.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_r <= {PW{1'b0}};
        end else if (xfer_s) begin
            rr_ptr_r <= ptr_next_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Write stage: one cycle after the handshake the regfile sees an active-low write.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_r   <= {AW{1'b0}};
            data_r <= {XLEN{1'b0}};
            we_l_r <= 1'b1;
        end else if (xfer_s) begin
            rd_r   <= sel_rd_s;
            data_r <= sel_data_s;
            we_l_r <= 1'b0;
        end else begin
            rd_r   <= rd_r;
            data_r <= data_r;
            we_l_r <= 1'b1;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forward the committing write to a matching non-zero source operand.
    always_comb begin
        byp1_s = !we_l_r && (rd_r != AW_ZERO_C) && (rd_r == issue_rs1);
        byp2_s = !we_l_r && (rd_r != AW_ZERO_C) && (rd_r == issue_rs2);
    end
`else
    // No forwarding path: sources wait until their pending bit has cleared.
    always_comb begin
        byp1_s = 1'b0;
        byp2_s = 1'b0;
    end
`endif

    // Hazard detection: RAW on either source (unless bypassed) and WAW on the destination.
    always_comb begin
        haz1_s       = pending_r[issue_rs1] && !byp1_s;
        haz2_s       = pending_r[issue_rs2] && !byp2_s;
        stall_s      = issue_valid && (haz1_s || haz2_s || pending_r[issue_rd]);
        issue_fire_s = issue_valid && !stall_s && (issue_rd != AW_ZERO_C);
    end

    // Scoreboard set/clear vectors; the clear follows the regfile capture edge.
    always_comb begin
        if (issue_fire_s) begin
            set_vec_s = REG_ONE_C << issue_rd;
        end else begin
            set_vec_s = REG_ZERO_C;
        end
        if (!we_l_r) begin
            clr_vec_s = REG_ONE_C << rd_r;
        end else begin
            clr_vec_s = REG_ZERO_C;
        end
    end

    // Scoreboard update: set beats clear, and x0 is never tracked.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_r <= REG_ZERO_C;
        end else begin
            pending_r <= ((pending_r & ~clr_vec_s) | set_vec_s) & ~REG_ONE_C;
        end
    end

    assign wb_ready     = ready_s;
    assign issue_stall  = stall_s;
    assign rd           = rd_r;
    assign regWriteData = data_r;
    assign reg_WE_L     = we_l_r;
    assign byp1_valid   = byp1_s;
    assign byp2_valid   = byp2_s;

endmodule
